// File: rtl/gmsk_burst_feeder.sv
// GMSK burst feeder: strobe timing and serialisation of one differentially
// encoded GSM normal burst (tail, data, steal, training, guard).
// Ports:
//   clock, reset_n            : system clock, async active-low reset
//   start_burst               : one-cycle burst request, honoured in IDLE
//   tsc_bits[25:0]            : training sequence, MSB first, latched at start
//   steal_bits[1:0]           : stealing flags ([1] first), latched at start
//   data_bit/valid/ready      : serial payload handshake
//   sample_strobe             : one pulse every CLOCKS_PER_SAMPLE clocks
//   symbol_strobe             : one pulse per symbol, a clock before a sample
//   input_bit                 : encoded bit for the modulator
//   burst_active, burst_done  : burst framing
//   underrun                  : sticky, a payload bit was missing
module gmsk_burst_feeder #(
  parameter int SAMPLES_PER_SYMBOL = 32,
  parameter int CLOCKS_PER_SAMPLE  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_burst,
  input  logic [25:0] tsc_bits,
  input  logic [1:0]  steal_bits,
  input  logic        data_bit,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        sample_strobe,
  output logic        symbol_strobe,
  output logic        input_bit,
  output logic        burst_active,
  output logic        burst_done,
  output logic        underrun
);

  localparam int DW = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam int SW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [DW-1:0] DIV_SYM  = DW'(CLOCKS_PER_SAMPLE - 2);
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [6:0]    PAYLOAD  = 7'd114;

  typedef enum logic [3:0] {
    IDLE, TAIL_A, DATA_A, STEAL_A, TRAIN,
    STEAL_B, DATA_B, TAIL_B, GUARD
  } state_t;

  function automatic logic [5:0] last_of(input state_t s);
    unique case (s)
      TAIL_A, TAIL_B: last_of = 6'd2;
      DATA_A, DATA_B: last_of = 6'd56;
      TRAIN:          last_of = 6'd25;
      GUARD:          last_of = 6'd7;
      default:        last_of = 6'd0;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    unique case (s)
      IDLE:    next_of = TAIL_A;
      TAIL_A:  next_of = DATA_A;
      DATA_A:  next_of = STEAL_A;
      STEAL_A: next_of = TRAIN;
      TRAIN:   next_of = STEAL_B;
      STEAL_B: next_of = DATA_B;
      DATA_B:  next_of = TAIL_B;
      TAIL_B:  next_of = GUARD;
      default: next_of = IDLE;
    endcase
  endfunction

  logic [DW-1:0] div_q, div_n;
  logic [SW-1:0] smp_q, smp_n;
  logic          tick;
  state_t        st_q, st_n;
  logic [5:0]    cnt_q, cnt_n;
  logic [25:0]   tsc_q;
  logic [1:0]    steal_q;
  logic          prev_q;
  logic          pend_q;
  logic          skid_full, skid_bit;
  logic [6:0]    fetch_q;
  logic          xfer, is_data, raw;

  assign data_ready = (burst_active | pend_q) & ~skid_full
                    & (fetch_q < PAYLOAD);
  assign xfer = data_valid & data_ready;

  // tick marks the edge that raises symbol_strobe; every symbol-level
  // output changes on that edge so it is stable through the strobe cycle.
  always_comb begin
    div_n = div_q + DW'(1);
    smp_n = smp_q;
    if (div_q == DIV_LAST) begin
      div_n = '0;
      smp_n = (smp_q == SMP_LAST) ? '0 : smp_q + SW'(1);
    end
    tick = (div_n == DIV_SYM) && (smp_n == SMP_LAST);
  end

  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q + 6'd1;
    if (st_q == IDLE || cnt_q == last_of(st_q)) begin
      st_n  = next_of(st_q);
      cnt_n = '0;
    end
    is_data = (st_n == DATA_A) || (st_n == DATA_B);
    unique case (1'b1)
      // An empty skid can be bypassed by a bit arriving in the tick cycle.
      is_data:          raw = skid_full ? skid_bit : (xfer & data_bit);
      st_n == STEAL_A:  raw = steal_q[1];
      st_n == STEAL_B:  raw = steal_q[0];
      st_n == TRAIN:    raw = tsc_q[5'd25 - cnt_n[4:0]];
      default:          raw = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      smp_q         <= '0;
      sample_strobe <= 1'b0;
      symbol_strobe <= 1'b0;
      st_q          <= IDLE;
      cnt_q         <= '0;
      tsc_q         <= '0;
      steal_q       <= '0;
      prev_q        <= 1'b1;
      pend_q        <= 1'b0;
      skid_full     <= 1'b0;
      skid_bit      <= 1'b0;
      fetch_q       <= '0;
      input_bit     <= 1'b0;
      burst_active  <= 1'b0;
      burst_done    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      div_q         <= div_n;
      smp_q         <= smp_n;
      sample_strobe <= (div_n == DIV_LAST);
      symbol_strobe <= tick;
      burst_done    <= 1'b0;
      if (xfer) begin
        skid_full <= 1'b1;
        skid_bit  <= data_bit;
        fetch_q   <= fetch_q + 7'd1;
      end
      if (st_q == IDLE && start_burst) begin
        tsc_q     <= tsc_bits;
        steal_q   <= steal_bits;
        underrun  <= 1'b0;
        pend_q    <= 1'b1;
        fetch_q   <= '0;
        skid_full <= 1'b0;
      end
      if (tick) begin
        if (st_q == IDLE) begin
          if (pend_q | start_burst) begin
            st_q         <= TAIL_A;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            burst_active <= 1'b1;
            // first tail 0 against the preset prev of 1
            input_bit    <= 1'b1;
            prev_q       <= 1'b0;
          end
        end else if (st_n == IDLE) begin
          st_q         <= IDLE;
          cnt_q        <= '0;
          burst_active <= 1'b0;
          burst_done   <= 1'b1;
          input_bit    <= 1'b0;
          prev_q       <= 1'b1;
        end else begin
          st_q      <= st_n;
          cnt_q     <= cnt_n;
          input_bit <= raw ^ prev_q;
          prev_q    <= raw;
          if (is_data) begin
            skid_full <= 1'b0;
            // a missing bit still uses up its payload slot
            if (!skid_full) begin
              fetch_q <= fetch_q + 7'd1;
              if (!xfer) underrun <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gmsk_burst_feeder.sv
// Directed bench for gmsk_burst_feeder: strobe cadence, burst framing,
// differential coding, underrun, ignored restart and mid-burst reset.
module tb_gmsk_burst_feeder;

  localparam int SPS = 8;
  localparam int CPS = 4;
  localparam int P   = SPS * CPS;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_burst = 1'b0;
  logic [25:0] tsc_bits = '0;
  logic [1:0]  steal_bits = '0;
  logic        data_bit = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready, sample_strobe, symbol_strobe;
  logic        input_bit, burst_active, burst_done, underrun;
  logic        d_ready, d_sample, d_symbol, d_ib, d_active, d_done, d_ur;

  int checks = 0;
  int errors = 0;

  logic [113:0] pay_v = '0;
  int ptr = 0;
  int hold_lo = 999;
  int hold_hi = -1;
  int sidx = 0;
  int done_cnt = 0;
  int act_bad = 0;
  int lat = 0;
  logic ur_after = 1'b0;
  logic [155:0] ib_v = '0;
  logic [155:0] ur_v = '0;

  always #5 clock = ~clock;

  gmsk_burst_feeder #(
    .SAMPLES_PER_SYMBOL(SPS),
    .CLOCKS_PER_SAMPLE(CPS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_burst(start_burst),
    .tsc_bits(tsc_bits), .steal_bits(steal_bits),
    .data_bit(data_bit), .data_valid(data_valid), .data_ready(data_ready),
    .sample_strobe(sample_strobe), .symbol_strobe(symbol_strobe),
    .input_bit(input_bit), .burst_active(burst_active),
    .burst_done(burst_done), .underrun(underrun)
  );

  gmsk_burst_feeder u_def (
    .clock(clock), .reset_n(reset_n), .start_burst(1'b0),
    .tsc_bits(26'h0), .steal_bits(2'b00),
    .data_bit(1'b0), .data_valid(1'b0), .data_ready(d_ready),
    .sample_strobe(d_sample), .symbol_strobe(d_symbol),
    .input_bit(d_ib), .burst_active(d_active),
    .burst_done(d_done), .underrun(d_ur)
  );

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [155:0] frame(input logic [113:0] pay,
      input logic [25:0] tsc, input logic [1:0] st, input int lo, input int hi);
    logic [155:0] f;
    logic b;
    f = '0;
    for (int j = 0; j < 114; j++) begin
      b = (j >= lo && j <= hi) ? 1'b0 : pay[j];
      if (j < 57) f[152 - j] = b;
      else f[155 - (88 + j - 57)] = b;
    end
    f[155 - 60] = st[1];
    for (int k = 0; k < 26; k++) f[155 - (61 + k)] = tsc[25 - k];
    f[155 - 87] = st[0];
    return f;
  endfunction

  function automatic logic [155:0] decode(input logic [155:0] ib);
    logic [155:0] r;
    logic p;
    p = 1'b1;
    for (int s = 0; s < 156; s++) begin
      r[155 - s] = ib[155 - s] ^ p;
      p = r[155 - s];
    end
    return r;
  endfunction

  task automatic feeder();
    logic hs;
    forever begin
      @(negedge clock);
      if (!burst_active) sidx = 0;
      else if (symbol_strobe) sidx++;
      if (ptr >= hold_lo && ptr <= hold_hi && sidx >= hold_hi + 4)
        ptr = hold_hi + 1;
      if (ptr >= hold_lo && ptr <= hold_hi) begin
        data_valid = 1'b0;
      end else begin
        data_valid = (ptr < 114);
        data_bit = (ptr < 114) ? pay_v[ptr] : 1'b0;
      end
      hs = data_valid & data_ready;
      @(posedge clock);
      if (hs) ptr++;
    end
  endtask

  task automatic wait_sym(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (burst_done) done_cnt++;
    end while (!symbol_strobe && n < 300);
    if (!symbol_strobe) begin
      checks++;
      errors++;
      $error("FAIL sym_timeout waited %0d required <300", n);
    end
  endtask

  task automatic begin_burst(input logic [113:0] pay, input logic [25:0] tsc,
      input logic [1:0] st, input int lo, input int hi, input int off);
    int n;
    wait_sym(n);
    repeat (off) @(negedge clock);
    pay_v = pay;
    ptr = 0;
    hold_lo = lo;
    hold_hi = hi;
    tsc_bits = tsc;
    steal_bits = st;
    start_burst = 1'b1;
    @(negedge clock);
    start_burst = 1'b0;
    ur_after = underrun;
    chk("ready_after_start", data_ready, 1'b1);
    done_cnt = 0;
    wait_sym(lat);
    chk("start_latency", {lat, burst_active}, {P - 1 - off, 1'b1});
  endtask

  task automatic capture(input int nsym, input int mid);
    int n;
    act_bad = 0;
    for (int s = 0; s < nsym; s++) begin
      if (s > 0) wait_sym(n);
      ib_v[155 - s] = input_bit;
      ur_v[155 - s] = underrun;
      if (!burst_active) act_bad++;
      if (s == mid) begin
        @(negedge clock);
        start_burst = 1'b1;
        tsc_bits = 26'h0;
        steal_bits = 2'b11;
        @(negedge clock);
        start_burst = 1'b0;
      end
    end
  endtask

  task automatic finish_burst(input logic [155:0] exp_raw, input string tag);
    int n;
    wait_sym(n);
    chk({tag, "_end"}, {burst_done, burst_active, input_bit}, 3'b100);
    @(negedge clock);
    chk({tag, "_done_once"}, {done_cnt, burst_done}, {32'd1, 1'b0});
    chk({tag, "_raw"}, decode(ib_v), exp_raw);
    chk({tag, "_active"}, act_bad, 0);
  endtask

  initial begin
    logic [113:0] alt, pat;
    logic [155:0] raw_t, exp_t;
    int s_bad, y_cnt, y_bad, both, q_cnt, first_sym, n;

    fork
      feeder();
    join_none

    repeat (3) @(negedge clock);
    chk("reset_dut", {data_ready, sample_strobe, symbol_strobe, input_bit,
        burst_active, burst_done, underrun}, 7'd0);
    chk("reset_def", {d_ready, d_sample, d_symbol, d_ib,
        d_active, d_done, d_ur}, 7'd0);

    reset_n = 1'b1;
    s_bad = 0; y_cnt = 0; y_bad = 0; both = 0; q_cnt = 0; first_sym = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clock);
      if (d_sample !== (i % 4 == 3)) s_bad++;
      if (d_symbol !== (i % 128 == 126)) y_bad++;
      if (d_symbol) y_cnt++;
      if (d_symbol && d_sample) both++;
      if (sample_strobe) q_cnt++;
      if (symbol_strobe && first_sym == 0) first_sym = i;
    end
    chk("cadence_sample", s_bad, 0);
    chk("cadence_symbol", {y_cnt, y_bad, both}, {32'd3, 32'd0, 32'd0});
    chk("small_cadence", {q_cnt, first_sym}, {32'd100, P - 2});

    // framing: zero payload, known TSC
    begin_burst('0, 26'h0970897, 2'b00, 999, -1, 10);
    capture(156, -1);
    finish_burst(frame('0, 26'h0970897, 2'b00, 999, -1), "frame");
    chk("frame_no_underrun", underrun, 1'b0);

    // differential: alternating payload, start in a strobe cycle
    for (int j = 0; j < 114; j++) alt[j] = ~j[0];
    begin_burst(alt, 26'h2A5C3F1, 2'b10, 999, -1, 0);
    capture(156, -1);
    chk("diff_head", ib_v[155:150], 6'b100111);
    finish_burst(frame(alt, 26'h2A5C3F1, 2'b10, 999, -1), "diff");

    // underrun on payload 10..12
    pat = 114'h2_F0E1_D2C3_B4A5_9687_7869_5A4B_3C2D;
    begin_burst(pat, 26'h1234567, 2'b01, 10, 12, 5);
    capture(156, -1);
    chk("underrun_edge", {ur_v[155 - 12], ur_v[155 - 13]}, 2'b01);
    finish_burst(frame(pat, 26'h1234567, 2'b01, 10, 12), "under");
    chk("underrun_sticky", underrun, 1'b1);

    // restart request during TRAIN is ignored
    begin_burst(~pat, 26'h3FF0055, 2'b01, 999, -1, 25);
    chk("underrun_cleared", ur_after, 1'b0);
    capture(156, 70);
    finish_burst(frame(~pat, 26'h3FF0055, 2'b01, 999, -1), "midtrain");

    // reset during DATA_B
    begin_burst(pat, 26'h0970897, 2'b11, 999, -1, 3);
    capture(101, -1);
    raw_t = decode(ib_v);
    exp_t = frame(pat, 26'h0970897, 2'b11, 999, -1);
    chk("pre_reset_raw", raw_t[155:55], exp_t[155:55]);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("reset_async", {data_ready, sample_strobe, symbol_strobe, input_bit,
        burst_active, burst_done, underrun}, 7'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_sym(n);
    chk("reset_restart", {n, burst_active, input_bit}, {P - 2, 2'b00});

    // clean burst after reset
    begin_burst('1, 26'h0970897, 2'b11, 999, -1, 10);
    capture(156, -1);
    finish_burst(frame('1, 26'h0970897, 2'b11, 999, -1), "after_reset");
    chk("after_reset_no_underrun", underrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmsk_burst_feeder.md
# gmsk_burst_feeder

Upstream stage of the GMSK modulator. It generates the modulator's `sample_strobe` and `symbol_strobe` timing and serialises one GSM normal burst onto `input_bit`. A burst is tail, data, stealing flags, training sequence and guard, differentially encoded. Payload bits arrive over a valid/ready serial interface; the training sequence and stealing flags are latched at burst start.

## Interface
- `SAMPLES_PER_SYMBOL`, default 32: samples per symbol; must equal the modulator ROM depth.
- `CLOCKS_PER_SAMPLE`, default 4: clocks between `sample_strobe` pulses; must be ≥2.
- `clock` input, 1: single system clock; all logic on its rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `start_burst` input, 1: one-cycle request; honoured only in IDLE.
- `tsc_bits` input, 26: training sequence, MSB sent first; latched with `start_burst`.
- `steal_bits` input, 2: [1] is the first stealing flag, [0] the second; latched with `start_burst`.
- `data_bit` input, 1: payload bit.
- `data_valid` input, 1: `data_bit` is valid.
- `data_ready` output, 1: block accepts `data_bit` this cycle.
- `sample_strobe` output, 1: one-cycle pulse every `CLOCKS_PER_SAMPLE` clocks.
- `symbol_strobe` output, 1: one-cycle pulse per symbol.
- `input_bit` output, 1: differentially encoded bit for the modulator.
- `burst_active` output, 1: high from the first tail symbol through the last guard symbol.
- `burst_done` output, 1: one-cycle pulse after the last guard symbol.
- `underrun` output, 1: sticky; set if a payload bit was needed but absent. Cleared by an accepted `start_burst`.

## Operation
- Strobe generator runs continuously while out of reset:
  - Clock divider counts 0..`CLOCKS_PER_SAMPLE`-1. `sample_strobe` is high when it equals `CLOCKS_PER_SAMPLE`-1.
  - Sample counter counts 0..`SAMPLES_PER_SYMBOL`-1 and advances on each `sample_strobe`.
  - `symbol_strobe` is high in the cycle where the divider equals `CLOCKS_PER_SAMPLE`-2 and the sample counter equals `SAMPLES_PER_SYMBOL`-1. It therefore precedes the symbol's first `sample_strobe` by exactly one clock and never coincides with a `sample_strobe`.
- States and symbol counts: IDLE; TAIL_A (3); DATA_A (57); STEAL_A (1); TRAIN (26); STEAL_B (1); DATA_B (57); TAIL_B (3); GUARD (8).
  - Per-state symbol counter; the state advances on the `symbol_strobe` that emits the state's last symbol.
  - 156 symbols per burst.
- IDLE → TAIL_A on the first `symbol_strobe` after an accepted `start_burst`. GUARD → IDLE after its 8th symbol. `burst_done` pulses in the following cycle.
- Raw bit per state: tails and guard emit 0; DATA emits payload; STEAL_A emits `steal_bits[1]`; STEAL_B emits `steal_bits[0]`; TRAIN emits `tsc_bits[25]` down to `[0]`.
- Differential encoding: `input_bit` = raw XOR prev.
  - prev is preset to 1 on burst entry, then follows the raw bit.
  - In IDLE, `input_bit` = 0.
- Payload intake:
  - One-bit skid register plus a fetch counter 0..114.
  - `data_ready` = `burst_active` (or start accepted) AND skid empty AND fetch counter < 114.
  - Transfer occurs when `data_valid` and `data_ready` are both high.
  - Each DATA symbol consumes the skid. If the skid is empty, raw 0 is emitted, `underrun` is set, and the fetch counter still increments.
- `start_burst` outside IDLE is ignored; latched TSC and steal bits do not change.

## Timing
- Reset values: all counters 0; state IDLE; `input_bit` 0; `data_ready`, strobes, `burst_active`, `burst_done` and `underrun` all 0; prev 1; skid empty.
- Reset deassertion mid-burst restarts at IDLE with strobe phase 0. No partial burst resumes.
- `input_bit` and `burst_active` change only on the edge that raises `symbol_strobe`, and are stable for that whole strobe cycle and the full symbol.
- Symbol period = `SAMPLES_PER_SYMBOL` × `CLOCKS_PER_SAMPLE` clocks, 128 at defaults.
- `start_burst` to first tail symbol: at most one symbol period plus 1 clock.
- `start_burst` coinciding with `symbol_strobe` in IDLE is accepted, and the burst begins at the next `symbol_strobe`.
- Skid may be filled from acceptance onward; the first DATA_A bit can be prefetched during TAIL_A.

## Test plan
- Strobe cadence, default parameters: `sample_strobe` every 4 clocks; `symbol_strobe` every 128 clocks, exactly 1 clock before a `sample_strobe`, never simultaneous with it.
- Burst framing: payload all 0, `tsc_bits`=26'h0970897, `steal_bits`=2'b00. Decoded raw stream (`input_bit` XOR previous, seeded 1) = 0×3, 0×57, 0, TSC MSB-first, 0, 0×57, 0×3, 0×8. `burst_active` high 156 symbols; `burst_done` pulses once.
- Differential check: alternating payload 1,0,1,0… → `input_bit` of DATA_A starts 1,1,1… after tail bits 1,0,0.
- Underrun: hold `data_valid` low for payload bits 10–12 → those emit raw 0, `underrun`=1 after symbol 13; remaining bits shift correctly; next accepted `start_burst` clears `underrun`.
- `start_burst` pulsed mid-TRAIN with new `tsc_bits` → ignored; burst completes with the original TSC.
- `reset_n` low during DATA_B for 3 clocks → all outputs at reset values immediately; IDLE after release; new burst runs cleanly.
